guess_ctrl: RTL

//  Game controller for the 3-digit number-guessing lab. It sits directly upstream of the

---
 rtl/guess_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/guess_ctrl.sv
// Game controller for the 3-digit number-guessing lab: generates a secret
// target from an LFSR, assembles keypad guesses, sequences the external
// check stage and tracks attempts / win / lose.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for new_game
// GEN   | searching LFSR output for a valid target (3 distinct BCD digits)
// ENTRY | collecting digits, waiting for submit
// CHK1  | start_check high, check stage registers operands
// CHK2  | start_check high, check_result valid and captured
// EVAL  | result_valid pulse, attempt counted, decide win/lose/continue
// WIN   | game won, holding final guess
// LOSE  | game lost, target shown
module guess_ctrl #(
    parameter int          MAX_TRIES = 8,
    parameter logic [11:0] LFSR_SEED = 12'hACE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        btn_clear,
    input  logic        btn_submit,
    input  logic [5:0]  check_result,
    output logic [11:0] input_number,
    output logic [11:0] target_number,
    output logic        start_check,
    output logic [1:0]  digit_cnt,
    output logic [3:0]  tries,
    output logic [5:0]  last_result,
    output logic        result_valid,
    output logic        win,
    output logic        lose
);

    typedef enum logic [2:0] {
        IDLE, GEN, ENTRY, CHK1, CHK2, EVAL, WIN, LOSE
    } state_t;

    localparam logic [4:0] MAX_T = 5'(MAX_TRIES);

    state_t      state, state_nxt;
    logic [11:0] lfsr;
    logic        lfsr_fb;
    logic        gen_ok;
    logic        pos_ok_three;
    logic [11:0] input_nxt, target_nxt;
    logic [1:0]  cnt_nxt;
    logic [3:0]  tries_nxt;
    logic [5:0]  result_nxt;

    assign lfsr_fb = lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0];

    // Candidate target: every nibble a decimal digit and all three distinct
    assign gen_ok = (lfsr[11:8] <= 4'd9) && (lfsr[7:4] <= 4'd9) && (lfsr[3:0] <= 4'd9) &&
                    (lfsr[11:8] != lfsr[7:4]) && (lfsr[11:8] != lfsr[3:0]) &&
                    (lfsr[7:4] != lfsr[3:0]);

    // Only the exact one-hot code for 3 counts as a full match; illegal codes never win
    assign pos_ok_three = (check_result[5:3] == 3'b100);

    // LFSR runs free in every state so the target depends on player timing
    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[10:0], lfsr_fb};
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            input_number  <= '0;
            target_number <= '0;
            digit_cnt     <= '0;
            tries         <= '0;
            last_result   <= '0;
        end else begin
            state         <= state_nxt;
            input_number  <= input_nxt;
            target_number <= target_nxt;
            digit_cnt     <= cnt_nxt;
            tries         <= tries_nxt;
            last_result   <= result_nxt;
        end
    end

    // Next-state and datapath update; new_game overrides everything
    always_comb begin
        state_nxt  = state;
        input_nxt  = input_number;
        target_nxt = target_number;
        cnt_nxt    = digit_cnt;
        tries_nxt  = tries;
        result_nxt = last_result;
        case (state)
            GEN: begin
                if (gen_ok) begin
                    target_nxt = lfsr;
                    state_nxt  = ENTRY;
                end
            end
            ENTRY: begin
                if (btn_clear) begin
                    input_nxt = '0;
                    cnt_nxt   = '0;
                end else if (btn_submit) begin
                    if (digit_cnt == 2'd3) state_nxt = CHK1;
                end else if (digit_valid && (digit <= 4'd9) && (digit_cnt != 2'd3)) begin
                    input_nxt = {input_number[7:0], digit};
                    cnt_nxt   = digit_cnt + 2'd1;
                end
            end
            CHK1: state_nxt = CHK2;
            CHK2: begin
                result_nxt = check_result;
                state_nxt  = EVAL;
            end
            EVAL: begin
                tries_nxt = (tries == 4'd15) ? tries : tries + 4'd1;
                if (last_result[5:3] == 3'b100) begin
                    state_nxt = WIN;
                end else if (({1'b0, tries} + 5'd1) == MAX_T) begin
                    state_nxt = LOSE;
                end else begin
                    state_nxt = ENTRY;
                    input_nxt = '0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = state;
        endcase
        if (new_game) begin
            state_nxt  = GEN;
            input_nxt  = '0;
            cnt_nxt    = '0;
            tries_nxt  = '0;
            result_nxt = '0;
        end
    end

    // Status outputs decoded straight from state
    always_comb begin
        start_check  = (state == CHK1) || (state == CHK2);
        result_valid = (state == EVAL);
        win          = (state == WIN);
        lose         = (state == LOSE);
    end

    logic unused_ok;
    assign unused_ok = pos_ok_three;

endmodule
